// File: rtl/bram_fifo_ctrl.sv
// FIFO controller for an external simple-dual-port block RAM with a registered read port.
// A 2-entry output buffer hides the RAM read latency so one push and one pop can happen every cycle.
module bram_fifo_ctrl #(
    parameter int DW = 36,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          ram_enA,
    output logic          ram_weA,
    output logic [AW-1:0] ram_addrA,
    output logic [DW-1:0] ram_dinA,
    output logic          ram_enB,
    output logic          ram_weB,
    output logic [AW-1:0] ram_addrB,
    input  logic [DW-1:0] ram_doutB,
    output logic [AW+1:0] level,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

    logic [AW:0]   wPtr, rPtr, ramCnt;
    logic [1:0]    obufCnt;
    logic          inflight;
    logic [DW-1:0] obufHead, obufTail;
    logic          push, pop, issue, capture, credit;

    assign ramCnt  = wPtr - rPtr;
    assign full    = (ramCnt == FULL_CNT);
    assign s_ready = !full && !clear && rst_n;
    assign push    = s_valid && s_ready;

    assign m_valid = (obufCnt != 2'd0);
    assign m_data  = obufHead;
    assign pop     = m_valid && m_ready && !clear;

    // Reads only go out when the output buffer is guaranteed room for the return word.
    assign credit  = ({1'b0, obufCnt} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
    assign issue   = rst_n && !clear && (ramCnt != '0) && credit;
    // A word returning during a flush is dropped on the floor.
    assign capture = inflight && !clear;

    assign ram_enA   = push;
    assign ram_weA   = push;
    assign ram_addrA = wPtr[AW-1:0];
    assign ram_dinA  = s_data;
    assign ram_enB   = issue;
    assign ram_weB   = 1'b0;
    assign ram_addrB = rPtr[AW-1:0];

    assign level = {1'b0, ramCnt} + {{(AW+1){1'b0}}, inflight} + {{AW{1'b0}}, obufCnt};
    assign empty = (level == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wPtr     <= '0;
            rPtr     <= '0;
            inflight <= 1'b0;
            obufCnt  <= 2'd0;
        end else if (clear) begin
            wPtr     <= '0;
            rPtr     <= '0;
            inflight <= 1'b0;
            obufCnt  <= 2'd0;
        end else begin
            if (push)
                wPtr <= wPtr + PTR_ONE;
            if (issue)
                rPtr <= rPtr + PTR_ONE;
            inflight <= issue;
            if (capture && !pop)
                obufCnt <= obufCnt + 2'd1;
            else if (!capture && pop)
                obufCnt <= obufCnt - 2'd1;
        end
    end

    // Head always holds the oldest word; tail is only used while two words are buffered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obufHead <= '0;
            obufTail <= '0;
        end else begin
            case ({capture, pop})
                2'b10: begin
                    if (obufCnt == 2'd0)
                        obufHead <= ram_doutB;
                    else
                        obufTail <= ram_doutB;
                end
                2'b01: obufHead <= obufTail;
                2'b11: begin
                    if (obufCnt == 2'd1) begin
                        obufHead <= ram_doutB;
                    end else begin
                        obufHead <= obufTail;
                        obufTail <= ram_doutB;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Bench for bram_fifo_ctrl: behavioural RAM plus a queue-based model of FIFO contents.
module tb_bram_fifo_ctrl;

    localparam int DW    = 36;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n, clear, s_valid, s_ready, m_valid, m_ready;
    logic [DW-1:0] s_data, m_data;
    logic          ram_enA, ram_weA, ram_enB, ram_weB;
    logic [AW-1:0] ram_addrA, ram_addrB;
    logic [DW-1:0] ram_dinA, ram_doutB;
    logic [AW+1:0] level;
    logic          full, empty;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] q [$];
    int nAssert = 0;
    int nFail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_enA && ram_weA) mem[ram_addrA] <= ram_dinA;
        if (ram_enB && !ram_weB) ram_doutB <= mem[ram_addrB];
    end

    bram_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .ram_enA(ram_enA), .ram_weA(ram_weA), .ram_addrA(ram_addrA), .ram_dinA(ram_dinA),
        .ram_enB(ram_enB), .ram_weB(ram_weB), .ram_addrB(ram_addrB), .ram_doutB(ram_doutB),
        .level(level), .full(full), .empty(empty)
    );

    task automatic test_reset;
        rst_n = 1'b0; clear = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
        repeat (3) @(negedge clk);
        nAssert++;
        if ({s_ready, m_valid, ram_enA, ram_weA, ram_enB, ram_weB, full, empty} !== 8'b0000_0001 || level !== '0) begin
            nFail++;
            $display("FAIL reset_state got rdy=%b mv=%b enA=%b weA=%b enB=%b weB=%b full=%b empty=%b level=%0d exp 0 0 0 0 0 0 0 1 level 0",
                     s_ready, m_valid, ram_enA, ram_weA, ram_enB, ram_weB, full, empty, level);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        nAssert++;
        if (s_ready !== 1'b1) begin nFail++; $display("FAIL reset_release_ready got %b exp 1", s_ready); end
    endtask

    task automatic test_single;
        @(posedge clk); #1 s_valid = 1'b1; s_data = 36'h123456789; m_ready = 1'b1;
        @(negedge clk);
        nAssert++;
        if (ram_enA !== 1'b1 || ram_weA !== 1'b1 || ram_dinA !== 36'h123456789 || ram_addrA !== '0) begin
            nFail++; $display("FAIL single_write got en=%b we=%b din=%h addr=%0d exp 1 1 123456789 0", ram_enA, ram_weA, ram_dinA, ram_addrA);
        end
        @(posedge clk); #1 s_valid = 1'b0;
        @(negedge clk);
        nAssert++;
        if (m_valid !== 1'b0 || ram_enB !== 1'b1 || int'(level) !== 1) begin
            nFail++; $display("FAIL single_issue got mv=%b enB=%b level=%0d exp 0 1 1", m_valid, ram_enB, level);
        end
        @(negedge clk);
        nAssert++;
        if (m_valid !== 1'b0) begin nFail++; $display("FAIL single_early_valid got %b exp 0", m_valid); end
        @(negedge clk);
        nAssert++;
        if (m_valid !== 1'b1 || m_data !== 36'h123456789 || int'(level) !== 1) begin
            nFail++; $display("FAIL single_present got mv=%b data=%h level=%0d exp 1 123456789 1", m_valid, m_data, level);
        end
        @(negedge clk);
        nAssert++;
        if (m_valid !== 1'b0 || int'(level) !== 0 || empty !== 1'b1) begin
            nFail++; $display("FAIL single_drained got mv=%b level=%0d empty=%b exp 0 0 1", m_valid, level, empty);
        end
    endtask

    task automatic test_fill;
        int acc = 0;
        int exp = 0;
        m_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1 s_valid = 1'b1; s_data = DW'(acc);
            @(negedge clk);
            if (s_ready) acc++;
        end
        @(posedge clk); #1 s_valid = 1'b0;
        @(negedge clk);
        nAssert++;
        if (acc !== DEPTH + 2 || int'(level) !== DEPTH + 2 || full !== 1'b1 || s_ready !== 1'b0) begin
            nFail++; $display("FAIL fill_limit got acc=%0d level=%0d full=%b rdy=%b exp %0d %0d 1 0", acc, level, full, s_ready, DEPTH + 2, DEPTH + 2);
        end
        for (int c = 0; c < 80 && exp < acc; c++) begin
            @(posedge clk); #1 m_ready = 1'b1;
            @(negedge clk);
            if (m_valid) begin
                nAssert++;
                if (m_data !== DW'(exp)) begin nFail++; $display("FAIL fill_order got %0d exp %0d", m_data, exp); end
                exp++;
            end
        end
        @(negedge clk);
        nAssert++;
        if (exp !== acc || empty !== 1'b1) begin nFail++; $display("FAIL fill_drain got popped=%0d empty=%b exp %0d 1", exp, empty, acc); end
    endtask

    task automatic test_stream;
        int n = 5000;
        int pushCnt = 0, popCnt = 0, gaps = 0, notReady = 0;
        bit started = 0;
        m_ready = 1'b1;
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1 s_valid = 1'b1; s_data = DW'(pushCnt);
            @(negedge clk);
            if (!s_ready) notReady++;
            if (m_valid) begin
                nAssert++;
                if (m_data !== DW'(popCnt)) begin nFail++; $display("FAIL stream_order got %0d exp %0d", m_data, popCnt); end
                popCnt++; started = 1;
            end else if (started) gaps++;
            if (s_ready) pushCnt++;
        end
        @(posedge clk); #1 s_valid = 1'b0;
        nAssert++;
        if (popCnt !== n - 3 || gaps !== 0 || notReady !== 0) begin
            nFail++; $display("FAIL stream_rate got pops=%0d gaps=%0d stalls=%0d exp %0d 0 0", popCnt, gaps, notReady, n - 3);
        end
        for (int c = 0; c < 20 && popCnt < pushCnt; c++) begin
            @(negedge clk);
            if (m_valid) begin
                nAssert++;
                if (m_data !== DW'(popCnt)) begin nFail++; $display("FAIL stream_tail got %0d exp %0d", m_data, popCnt); end
                popCnt++;
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        nAssert++;
        if (popCnt !== pushCnt || empty !== 1'b1) begin nFail++; $display("FAIL stream_drain got pops=%0d empty=%b exp %0d 1", popCnt, empty, pushCnt); end
    endtask

    task automatic test_random;
        bit prevStall = 0;
        logic [DW-1:0] prevData = '0;
        q.delete();
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk); #1;
            s_valid = 1'($urandom_range(1));
            m_ready = 1'($urandom_range(1));
            s_data  = {4'($urandom), 32'($urandom)};
            @(negedge clk);
            nAssert++;
            if (int'(level) !== q.size() || empty !== (q.size() == 0)) begin
                nFail++; $display("FAIL rand_level got level=%0d empty=%b exp %0d", level, empty, q.size());
            end
            if (q.size() < DEPTH) begin
                nAssert++;
                if (s_ready !== 1'b1) begin nFail++; $display("FAIL rand_ready got %b exp 1 at occupancy %0d", s_ready, q.size()); end
            end
            if (prevStall) begin
                nAssert++;
                if (m_valid !== 1'b1 || m_data !== prevData) begin
                    nFail++; $display("FAIL rand_stable got mv=%b data=%h exp 1 %h", m_valid, m_data, prevData);
                end
            end
            if (m_valid && m_ready) begin
                nAssert++;
                if (q.size() == 0 || m_data !== q[0]) begin
                    nFail++; $display("FAIL rand_order got %h exp %h (model size %0d)", m_data, (q.size() != 0) ? q[0] : '0, q.size());
                end
                if (q.size() != 0) void'(q.pop_front());
            end
            if (s_valid && s_ready) q.push_back(s_data);
            prevStall = m_valid && !m_ready;
            prevData  = m_data;
        end
        @(posedge clk); #1 s_valid = 1'b0; m_ready = 1'b1;
        for (int c = 0; c < 60 && q.size() != 0; c++) begin
            @(negedge clk);
            if (m_valid) begin
                nAssert++;
                if (m_data !== q[0]) begin nFail++; $display("FAIL rand_drain got %h exp %h", m_data, q[0]); end
                void'(q.pop_front());
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        nAssert++;
        if (q.size() !== 0 || empty !== 1'b1) begin nFail++; $display("FAIL rand_empty got left=%0d empty=%b exp 0 1", q.size(), empty); end
    endtask

    task automatic test_clear;
        int seen = 0;
        bit got = 0;
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1 s_valid = 1'b1; s_data = DW'(36'hC00 + i);
        end
        @(posedge clk); #1 s_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 m_ready = 1'b1;
        @(negedge clk);
        nAssert++;
        if (m_data !== 36'hC00 || ram_enB !== 1'b1) begin nFail++; $display("FAIL clear_setup got data=%h enB=%b exp c00 1", m_data, ram_enB); end
        @(posedge clk); #1;
        nAssert++;
        if (ram_enB !== 1'b1) begin nFail++; $display("FAIL clear_issue_cycle got enB=%b exp 1", ram_enB); end
        clear = 1'b1;
        #1;
        nAssert++;
        if (ram_enB !== 1'b0 || s_ready !== 1'b0) begin nFail++; $display("FAIL clear_suppress got enB=%b rdy=%b exp 0 0", ram_enB, s_ready); end
        @(posedge clk); #1 clear = 1'b0;
        @(negedge clk);
        nAssert++;
        if (int'(level) !== 0 || empty !== 1'b1 || m_valid !== 1'b0) begin
            nFail++; $display("FAIL clear_result got level=%0d empty=%b mv=%b exp 0 1 0", level, empty, m_valid);
        end
        for (int c = 0; c < 5; c++) begin @(negedge clk); if (m_valid) seen++; end
        nAssert++;
        if (seen !== 0) begin nFail++; $display("FAIL clear_stale got %0d valid cycles exp 0", seen); end
        @(posedge clk); #1 s_valid = 1'b1; s_data = 36'h5A5A5A5A5;
        @(posedge clk); #1 s_valid = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (m_valid) begin
                got = 1;
                nAssert++;
                if (m_data !== 36'h5A5A5A5A5) begin nFail++; $display("FAIL clear_after_push got %h exp 5a5a5a5a5", m_data); end
            end
        end
        nAssert++;
        if (!got) begin nFail++; $display("FAIL clear_after_timeout got no m_valid exp one word"); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int stale = 0;
        m_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1 s_valid = 1'b1; s_data = DW'(36'h700 + i);
        end
        @(posedge clk); #1 s_data = 36'h7FF;
        nAssert++;
        if (int'(level) !== 7 || ram_enA !== 1'b1 || m_valid !== 1'b1) begin
            nFail++; $display("FAIL rstmid_setup got level=%0d enA=%b mv=%b exp 7 1 1", level, ram_enA, m_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        nAssert++;
        if (m_valid !== 1'b0 || ram_enA !== 1'b0 || ram_enB !== 1'b0 || s_ready !== 1'b0 || int'(level) !== 0 || empty !== 1'b1) begin
            nFail++; $display("FAIL rstmid_async got mv=%b enA=%b enB=%b rdy=%b level=%0d empty=%b exp 0 0 0 0 0 1",
                              m_valid, ram_enA, ram_enB, s_ready, level, empty);
        end
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        nAssert++;
        if (s_ready !== 1'b1 || int'(level) !== 0) begin nFail++; $display("FAIL rstmid_release got rdy=%b level=%0d exp 1 0", s_ready, level); end
        for (int c = 0; c < 5; c++) begin @(negedge clk); if (m_valid) stale++; end
        nAssert++;
        if (stale !== 0) begin nFail++; $display("FAIL rstmid_stale got %0d valid cycles exp 0", stale); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_random();
        test_clear();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
